goose_anim_ctrl: RTL
====================

# goose_anim_ctrl

Per-frame animation and placement controller for the spinning-goose VGA demo. It sits between the sync/timing generator and the frame/palette lookups. Once per video frame it advances the animation frame index and bounces the sprite origin around the 640x480 screen. Per pixel it converts the raw beam position into sprite-local lookup coordinates and an in-sprite flag, registered one cycle.

## Interface
Parameters:
- NUM_FRAMES, 4: animation frames cycled in the lookup stage (2..8).
- SCALE_SHIFT, 3: log2 of screen pixels per lookup cell.
- CELLS, 32: lookup cells per sprite axis; sprite extent = CELLS << SCALE_SHIFT = 256 px.
- STEP, 2: pixels moved per axis per frame tick.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high; one clock; the polarity and synchronicity are fixed.
- pix_x  in  10  beam column from the timing generator.
- pix_y  in  10  beam row from the timing generator.
- spin  in  1  request animation (button, already synchronised).
- speed  in  2  frame-advance rate select.
- frame_sel  out  3  current animation frame index.
- lut_x  out  5  sprite-local cell column.
- lut_y  out  5  sprite-local cell row.
- in_sprite  out  1  beam is inside the sprite box.

## Operation
- Frame tick: a one-cycle internal pulse when pix_x==0 && pix_y==480, the first blanking line. Position and frame index update only on a tick, so there is no tearing.
- Divider: a 3-bit div_cnt counts ticks. Frame advance occurs when div_cnt reaches (1<<(3-speed))-1, then div_cnt clears. This gives an advance every 8/4/2/1 ticks for speed 0/1/2/3.
- State machine (state sampled and changed only on a tick):
  - IDLE: frame_sel holds 0, position frozen. On spin=1 → SPIN.
  - SPIN: on advance, frame_sel = (frame_sel==NUM_FRAMES-1) ? 0 : frame_sel+1. Position moves every tick. On spin=0 → SETTLE.
  - SETTLE: advances and moves as in SPIN. When frame_sel wraps to 0 → IDLE, with the position frozen at its value after that tick. On spin=1 → SPIN.
- Bounce, per axis, with MAX = 384 for x (640-256) and 224 for y (480-256):
  - If dir=+ and pos+STEP ≥ MAX: pos = MAX, dir = −.
  - If dir=− and pos ≤ STEP: pos = 0, dir = +.
  - Otherwise pos ± STEP.
  - Compute in 11 bits; the stored pos is always within 0..MAX.
- Pixel mapping:
  - dx = pix_x − sprite_x and dy = pix_y − sprite_y, computed in 11 bits.
  - in_sprite = (dx < 256) && (dy < 256) && pix_x < 640 && pix_y < 480.
  - lut_x = dx[SCALE_SHIFT+4:SCALE_SHIFT], lut_y = dy[SCALE_SHIFT+4:SCALE_SHIFT].
  - When in_sprite=0, lut_x and lut_y are 0.

## Timing
- Reset values: state IDLE, div_cnt 0, frame_sel 0, sprite_x 192, sprite_y 112, both directions +, lut_x 0, lut_y 0, in_sprite 0.
- Reset wins over a coincident tick. Reset mid-SPIN returns to the reset values on the next edge.
- frame_sel, sprite_x and sprite_y change on the clock edge that samples the tick. They are visible from the next cycle, always inside vertical blanking.
- Pixel path latency is exactly 1 clock: lut_x, lut_y and in_sprite at cycle n+1 correspond to pix_x and pix_y at cycle n. The top level delays hsync, vsync and display_on by one register to match.
- In SETTLE, a tick that both wraps frame_sel to 0 and sees spin=1 goes to SPIN; spin takes priority.
- div_cnt is not cleared on state change. speed changes take effect at the next comparison.

## Structure
- goose_pkg: state enum (IDLE, SPIN, SETTLE), H_ACTIVE=640, V_ACTIVE=480, SPRITE_PX=256, X_MAX=384, Y_MAX=224, X_RST=192, Y_RST=112.
- Sub-module goose_bounce_axis (parameters MAX, RST, STEP): holds pos and dir for one axis, updates on an enable pulse. Instantiated twice.
- Everything else lives in goose_anim_ctrl: tick detect, divider, FSM, pixel map pipeline register.

## Test plan
- Reset, then drive two full frames with spin=0 → frame_sel=0, sprite stays at (192,112). Beam at (192,112) gives lut=(0,0), in_sprite=1 one clock later; beam at (191,112) gives in_sprite=0.
- spin=1, speed=3 → frame_sel steps 1,2,3,0 on successive ticks; sprite_x steps 194,196,…
- speed=0 → frame_sel advances every 8th tick only; speed=2 → every 2nd tick.
- Run until x reaches 384 → next ticks give x 382, 380 (direction flips). Start y=223 dir + → y=224, then 222.
- spin drops at frame_sel=2, speed=3 → SETTLE, frame_sel 3, then 0 → IDLE, position frozen. Re-asserting spin during SETTLE returns to SPIN.
- Assert reset on the tick cycle mid-SPIN → all outputs equal the reset values next cycle; no frame advance.

Source files
------------

// File: rtl/goose_pkg.sv
// Shared constants, state encoding and small helpers for the spinning-goose
// animation controller.
package goose_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    SETTLE = 2'd2
  } goose_state_e;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SPRITE_PX = 256;
  localparam int X_MAX     = H_ACTIVE - SPRITE_PX;
  localparam int Y_MAX     = V_ACTIVE - SPRITE_PX;
  localparam int X_RST     = 192;
  localparam int Y_RST     = 112;

  // Terminal count of the frame divider: advance every 8/4/2/1 ticks.
  function automatic logic [2:0] div_limit(input logic [1:0] speed);
    logic [2:0] lim;
    case (speed)
      2'd0:    lim = 3'd7;
      2'd1:    lim = 3'd3;
      2'd2:    lim = 3'd1;
      default: lim = 3'd0;
    endcase
    return lim;
  endfunction

  function automatic logic [2:0] next_frame(input logic [2:0] cur,
                                            input logic [2:0] last);
    logic [2:0] nxt;
    if (cur == last) nxt = 3'd0;
    else             nxt = cur + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/goose_bounce_axis.sv
// One axis of the sprite origin: a position that walks by STEP per enable
// pulse and reflects off 0 and MAX.
module goose_bounce_axis
  import goose_pkg::*;
#(
  parameter int MAX  = X_MAX,
  parameter int RST  = X_RST,
  parameter int STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] pos
);

  logic [9:0]  pos_q, pos_d;
  logic        dir_q, dir_d;
  logic [10:0] pos_w;
  logic [10:0] up_w;
  logic [10:0] dn_w;

  // dir_q = 0 means moving toward MAX, 1 means moving toward 0.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    pos_w = {1'b0, pos_q};
    up_w  = pos_w + 11'(STEP);
    dn_w  = pos_w - 11'(STEP);
    if (en) begin
      if (!dir_q) begin
        if (up_w >= 11'(MAX)) begin
          pos_d = 10'(MAX);
          dir_d = 1'b1;
        end else begin
          pos_d = up_w[9:0];
        end
      end else begin
        if (pos_w <= 11'(STEP)) begin
          pos_d = 10'd0;
          dir_d = 1'b0;
        end else begin
          pos_d = dn_w[9:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= 10'(RST);
      dir_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/goose_anim_ctrl.sv
// Per-frame animation/placement controller: frame tick, rate divider, spin
// state machine, two bouncing axes and the one-cycle pixel-to-cell mapping.
module goose_anim_ctrl
  import goose_pkg::*;
#(
  parameter int NUM_FRAMES  = 4,
  parameter int SCALE_SHIFT = 3,
  parameter int CELLS       = 32,
  parameter int STEP        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       spin,
  input  logic [1:0] speed,
  output logic [2:0] frame_sel,
  output logic [4:0] lut_x,
  output logic [4:0] lut_y,
  output logic       in_sprite
);

  localparam int         SPRITE_W   = CELLS << SCALE_SHIFT;
  localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES - 1);

  goose_state_e state_q, state_d;
  logic [2:0]   div_cnt_q, div_cnt_d;
  logic [2:0]   frame_q, frame_d;
  logic         tick;
  logic         advance;
  logic         move_en;
  logic [9:0]   sprite_x;
  logic [9:0]   sprite_y;

  // First line of vertical blanking: all per-frame state changes here so the
  // visible picture never tears.
  assign tick    = (pix_x == 10'd0) && (pix_y == 10'(V_ACTIVE));
  assign advance = tick && (div_cnt_q == div_limit(speed));
  assign move_en = tick && (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    div_cnt_d = div_cnt_q;
    if (tick) begin
      div_cnt_d = advance ? 3'd0 : div_cnt_q + 3'd1;
      case (state_q)
        IDLE: begin
          if (spin) state_d = SPIN;
        end
        SPIN: begin
          if (advance) frame_d = next_frame(frame_q, LAST_FRAME);
          if (!spin)   state_d = SETTLE;
        end
        SETTLE: begin
          if (advance) frame_d = next_frame(frame_q, LAST_FRAME);
          // A held button beats the wrap back to rest.
          if (spin)                             state_d = SPIN;
          else if (advance && frame_d == 3'd0)  state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          frame_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= 3'd0;
      frame_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      frame_q   <= frame_d;
    end
  end

  goose_bounce_axis #(
    .MAX  (X_MAX),
    .RST  (X_RST),
    .STEP (STEP)
  ) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .en    (move_en),
    .pos   (sprite_x)
  );

  goose_bounce_axis #(
    .MAX  (Y_MAX),
    .RST  (Y_RST),
    .STEP (STEP)
  ) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .en    (move_en),
    .pos   (sprite_y)
  );

  logic [10:0] dx, dy;
  logic        in_box;
  logic [4:0]  lut_x_q, lut_x_d;
  logic [4:0]  lut_y_q, lut_y_d;
  logic        in_sprite_q, in_sprite_d;

  // Beam left of / above the sprite wraps to a large 11-bit value, so the
  // single unsigned compare also rejects negative offsets.
  always_comb begin
    dx          = {1'b0, pix_x} - {1'b0, sprite_x};
    dy          = {1'b0, pix_y} - {1'b0, sprite_y};
    in_box      = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_W)) &&
                  (pix_x < 10'(H_ACTIVE)) && (pix_y < 10'(V_ACTIVE));
    in_sprite_d = in_box;
    lut_x_d     = in_box ? dx[SCALE_SHIFT+4:SCALE_SHIFT] : 5'd0;
    lut_y_d     = in_box ? dy[SCALE_SHIFT+4:SCALE_SHIFT] : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lut_x_q     <= 5'd0;
      lut_y_q     <= 5'd0;
      in_sprite_q <= 1'b0;
    end else begin
      lut_x_q     <= lut_x_d;
      lut_y_q     <= lut_y_d;
      in_sprite_q <= in_sprite_d;
    end
  end

  assign frame_sel = frame_q;
  assign lut_x     = lut_x_q;
  assign lut_y     = lut_y_q;
  assign in_sprite = in_sprite_q;

endmodule
